// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the unpipelined core.
// Fetches over a req/ack imem handshake, holds the instruction for execute, then applies PC_src.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        pc_src,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap_valid,
    output logic        trap_cause,
    output logic [31:0] trap_tval
);

    localparam int unsigned WCW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(FETCH_TIMEOUT - 1);
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_TRAP
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_ir;
    logic [WCW-1:0]  r_wait_cnt;
    logic            r_trap_cause;
    logic [31:0]     r_trap_tval;

    logic [31:0]     w_pc_plus4;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_j;
    logic [31:0]     w_target;
    logic [31:0]     w_next;
    logic            w_misaligned;

    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_imm_i    = {{20{r_ir[31]}}, r_ir[31:20]};
        w_imm_b    = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        w_imm_j    = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_target   = r_pc + w_imm_b;
        if (r_ir[6:0] == OPC_JAL) begin
            w_target = r_pc + w_imm_j;
        end else if (r_ir[6:0] == OPC_JALR) begin
            w_target = (rs1_data + w_imm_i) & ~32'h1;
        end
        w_next       = pc_src ? w_target : w_pc_plus4;
        w_misaligned = |w_next[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_ir         <= NOP;
            r_wait_cnt   <= '0;
            r_trap_cause <= 1'b0;
            r_trap_tval  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    // An ack arriving on the final allowed cycle takes priority over the timeout.
                    if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_wait_cnt <= '0;
                        r_state    <= S_EXEC;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_trap_cause <= 1'b1;
                        r_trap_tval  <= r_pc;
                        r_pc         <= TRAP_VEC;
                        r_wait_cnt   <= '0;
                        r_state      <= S_TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (w_misaligned) begin
                            r_trap_cause <= 1'b0;
                            r_trap_tval  <= w_next;
                            r_pc         <= TRAP_VEC;
                            r_state      <= S_TRAP;
                        end else begin
                            r_pc    <= w_next;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_TRAP: r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_out   = r_ir;
    assign instr_valid = (r_state == S_EXEC);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign trap_valid  = (r_state == S_TRAP);
    assign trap_cause  = r_trap_cause;
    assign trap_tval   = r_trap_tval;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then randomized fetch/execute traffic
// checked against a transaction-level PC model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC      = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC      = 32'h0000_0100;
    localparam int unsigned FETCH_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        exec_done;
    logic        pc_src;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap_valid;
    logic        trap_cause;
    logic [31:0] trap_tval;

    int          n_total;
    int          n_bad;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_cause;
    logic [31:0] m_tval;

    pc_fetch_unit #(
        .RESET_PC     (RESET_PC),
        .TRAP_VEC     (TRAP_VEC),
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .pc_src     (pc_src),
        .rs1_data   (rs1_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_tval  (trap_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Next-PC rule written with plain field arithmetic on the instruction word.
    function automatic logic [31:0] ref_next(input logic [31:0] pc_v, input logic [31:0] ir,
                                             input logic src, input logic [31:0] rs1);
        logic [31:0] imm;
        logic [31:0] opc;
        opc = ir & 32'h7f;
        if (!src) return pc_v + 32'd4;
        if (opc == 32'h6f) begin
            imm = ((ir >> 21) & 32'h3ff) * 32'd2 + ((ir >> 20) & 32'd1) * 32'd2048
                + ((ir >> 12) & 32'hff) * 32'd4096 - ((ir >> 31) & 32'd1) * 32'h0010_0000;
            return pc_v + imm;
        end
        if (opc == 32'h67) begin
            imm = (ir >> 20) - ((ir >> 31) & 32'd1) * 32'd4096;
            return (rs1 + imm) & 32'hFFFF_FFFE;
        end
        imm = ((ir >> 8) & 32'hf) * 32'd2 + ((ir >> 25) & 32'h3f) * 32'd32
            + ((ir >> 7) & 32'd1) * 32'd2048 - ((ir >> 31) & 32'd1) * 32'd4096;
        return pc_v + imm;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        pc_src    = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m_pc    = RESET_PC;
        m_cause = 1'b0;
        m_tval  = '0;
        #1;
        check("idle_req", imem_req, 1'b0);
        check("idle_pc", pc, RESET_PC);
        check("idle_pc4", pc_plus4, RESET_PC + 32'd4);
        check("idle_valid", instr_valid, 1'b0);
        check("idle_trap", trap_valid, 1'b0);
        check("idle_cause", trap_cause, 1'b0);
        check("idle_tval", trap_tval, 32'h0);
        check("idle_ir", instr_out, 32'h0000_0013);
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, m_pc);
    endtask

    task automatic fetch(input int unsigned delay, input logic [31:0] word);
        check("fetch_req", imem_req, 1'b1);
        check("fetch_addr", imem_addr, m_pc);
        for (int unsigned i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            exec_done  = 1'($urandom_range(0, 1));
            pc_src     = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        exec_done  = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        m_ir     = word;
        check("exec_valid", instr_valid, 1'b1);
        check("exec_instr", instr_out, word);
        check("exec_noreq", imem_req, 1'b0);
        check("exec_pc", pc, m_pc);
    endtask

    task automatic exec(input int unsigned hold, input logic src, input logic [31:0] rs1);
        logic [31:0] nxt;
        for (int unsigned i = 0; i < hold; i++) begin
            exec_done  = 1'b0;
            pc_src     = 1'($urandom_range(0, 1));
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr_out, m_ir);
            check("hold_pc", pc, m_pc);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        pc_src    = src;
        rs1_data  = rs1;
        @(negedge clk);
        exec_done = 1'b0;
        pc_src    = 1'b0;
        nxt = ref_next(m_pc, m_ir, src, rs1);
        if (nxt[1:0] == 2'b00) begin
            m_pc = nxt;
            check("next_req", imem_req, 1'b1);
            check("next_addr", imem_addr, m_pc);
            check("next_pc", pc, m_pc);
            check("next_pc4", pc_plus4, m_pc + 32'd4);
            check("next_notrap", trap_valid, 1'b0);
            check("next_novalid", instr_valid, 1'b0);
        end else begin
            m_cause = 1'b0;
            m_tval  = nxt;
            m_pc    = TRAP_VEC;
            check("mis_trap", trap_valid, 1'b1);
            check("mis_cause", trap_cause, m_cause);
            check("mis_tval", trap_tval, m_tval);
            check("mis_pc", pc, m_pc);
            check("mis_noreq", imem_req, 1'b0);
            @(negedge clk);
            check("mis_trap_end", trap_valid, 1'b0);
            check("mis_refetch", imem_req, 1'b1);
            check("mis_vec", imem_addr, TRAP_VEC);
            check("mis_cause_hold", trap_cause, m_cause);
            check("mis_tval_hold", trap_tval, m_tval);
        end
    endtask

    task automatic timeout_trap();
        for (int unsigned i = 0; i < FETCH_TIMEOUT - 1; i++) begin
            imem_ack  = 1'b0;
            exec_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("to_wait_req", imem_req, 1'b1);
            check("to_wait_notrap", trap_valid, 1'b0);
        end
        @(negedge clk);
        exec_done = 1'b0;
        m_cause = 1'b1;
        m_tval  = m_pc;
        m_pc    = TRAP_VEC;
        check("to_trap", trap_valid, 1'b1);
        check("to_cause", trap_cause, m_cause);
        check("to_tval", trap_tval, m_tval);
        check("to_pc", pc, m_pc);
        @(negedge clk);
        check("to_trap_end", trap_valid, 1'b0);
        check("to_refetch", imem_req, 1'b1);
        check("to_vec", imem_addr, TRAP_VEC);
    endtask

    task automatic reset_mid_exec();
        rst = 1'b1;
        #1;
        check("arst_valid", instr_valid, 1'b0);
        check("arst_req", imem_req, 1'b0);
        check("arst_pc", pc, RESET_PC);
        check("arst_cause", trap_cause, 1'b0);
        check("arst_tval", trap_tval, 32'h0);
        do_reset();
    endtask

    task automatic walk_nops(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            fetch(0, 32'h0000_0013);
            exec(0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] r;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        exec_done  = 1'b0;
        pc_src     = 1'b0;
        rs1_data   = '0;
        m_ir       = 32'h0000_0013;

        do_reset();
        fetch(3, 32'h0000_0013);
        exec(0, 1'b0, 32'h0);
        check("t2_pc", pc, 32'h4);

        walk_nops(3);
        fetch(2, 32'h0062_8c63);
        exec(2, 1'b1, 32'h0);
        check("beq_taken", pc, 32'h28);

        do_reset();
        walk_nops(4);
        fetch(1, 32'h0062_8c63);
        exec(0, 1'b0, 32'h0);
        check("beq_not_taken", pc, 32'h14);

        fetch(1, 32'h1003_02e7);
        exec(0, 1'b1, 32'h0000_2001);
        check("jalr_pc", pc, 32'h2100);
        check("jalr_notrap", trap_valid, 1'b0);

        fetch(0, 32'h1003_02e7);
        exec(0, 1'b1, 32'hFFFF_FF40);
        fetch(0, 32'h0080_02ef);
        exec(1, 1'b1, 32'h0);
        check("jal_pc", pc, 32'h48);

        fetch(0, 32'h1003_02e7);
        exec(0, 1'b1, 32'h0000_0002);
        check("jalr_mis_tval", trap_tval, 32'h102);
        check("jalr_mis_addr", imem_addr, 32'h100);

        fetch(0, 32'h1003_02e7);
        exec(0, 1'b1, 32'hFFFF_FEFC);
        check("wrap_top", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        fetch(0, 32'h0000_0013);
        exec(0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);

        fetch(FETCH_TIMEOUT - 1, 32'h0000_0013);
        exec(0, 1'b0, 32'h0);

        do_reset();
        walk_nops(2);
        timeout_trap();
        check("t6_cause", trap_cause, 1'b1);
        check("t6_tval", trap_tval, 32'h8);
        fetch(0, 32'h0000_0013);
        reset_mid_exec();

        for (int unsigned it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                timeout_trap();
            end else begin
                w = $urandom;
                case ($urandom_range(0, 3))
                    0: w[6:0] = 7'b0110011;
                    1: w[6:0] = 7'b1100011;
                    2: w[6:0] = 7'b1101111;
                    default: w[6:0] = 7'b1100111;
                endcase
                fetch(($urandom_range(0, 9) == 0) ? FETCH_TIMEOUT - 1 : $urandom_range(0, 3), w);
                if ($urandom_range(0, 24) == 0) begin
                    reset_mid_exec();
                end else begin
                    r = $urandom;
                    if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
                    exec($urandom_range(0, 3), 1'($urandom_range(0, 1)), r);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
